mbr_queue: RTL and testbench

Parametrised successor to the single memory buffer register. It holds the CPU-visible buffer value `mbr_data` and adds two things:
- a `DEPTH`-entry store queue that decouples accumulator writes from a memory write port using a valid/ready handshake;
- a load-wait state machine that captures memory read data whenever the memory responds.

It sits between the accumulator, the control unit and main memory, in place of the fixed 16-bit MBR.

---
 rtl/mbr_pkg.sv | 12 +
 rtl/mbr_store_fifo.sv | 57 +++++
 rtl/mbr_queue.sv | 105 ++++++++++
 tb/tb_mbr_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mbr_pkg.sv
// mbr_pkg: shared control-bit positions and load FSM encoding for the MBR queue
package mbr_pkg;

    localparam int CTRL_ACC2MBR = 10;
    localparam int CTRL_MEM2MBR = 5;

    typedef enum logic {
        LD_IDLE,
        LD_WAIT
    } ld_state_e;

endpackage

// File: rtl/mbr_store_fifo.sv
// mbr_store_fifo: synchronous store FIFO with occupancy count and full/empty flags
module mbr_store_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    import mbr_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // pointers wrap naturally; count moves only on push-only or pop-only cycles
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + CNT_W'(1) :
                   (pop && !push) ? count_q - CNT_W'(1) : count_q;
    end

    // pointer and occupancy state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // entry storage is left unreset; it is only observed while non-empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);

endmodule

// File: rtl/mbr_queue.sv
// mbr_queue: memory buffer register with a decoupled store queue and a load-wait FSM
module mbr_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       control_signals,
    input  logic [DATA_W-1:0] acc2mbr,
    input  logic [DATA_W-1:0] mem2mbr,
    input  logic              mem_rvalid,
    output logic [DATA_W-1:0] mbr_data,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              load_pending,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    import mbr_pkg::*;

    ld_state_e         state_q;
    logic              load_pending_q;
    logic [DATA_W-1:0] mbr_data_q, mbr_data_d;
    logic              overflow_q, overflow_d;
    logic              store, load_req, capture, push, pop;
    logic              ctrl_unused;

    // the store bit has legacy priority and masks a same-cycle load request
    assign store       = control_signals[CTRL_ACC2MBR];
    assign load_req    = control_signals[CTRL_MEM2MBR] && !store;
    assign capture     = mem_rvalid && (state_q == LD_WAIT || load_req);
    assign pop         = !empty && wr_ready;
    assign push        = store && (!full || pop);
    assign ctrl_unused = ^control_signals;

    // buffer value and sticky drop flag; a dropped store still updates the buffer
    always_comb begin
        mbr_data_d = store ? acc2mbr : capture ? mem2mbr : mbr_data_q;
        overflow_d = overflow_q || (store && !push);
    end

    // buffer and overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mbr_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            mbr_data_q <= mbr_data_d;
            overflow_q <= overflow_d;
        end
    end

    // load FSM: a request without read data parks in WAIT until the memory responds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= LD_IDLE;
            load_pending_q <= 1'b0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (load_req && !mem_rvalid) begin
                        state_q        <= LD_WAIT;
                        load_pending_q <= 1'b1;
                    end
                end
                LD_WAIT: begin
                    if (mem_rvalid) begin
                        state_q        <= LD_IDLE;
                        load_pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= LD_IDLE;
                    load_pending_q <= 1'b0;
                end
            endcase
        end
    end

    mbr_store_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_data(acc2mbr),
        .pop      (pop),
        .rd_data  (wr_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign wr_valid     = !empty;
    assign mbr_data     = mbr_data_q;
    assign overflow     = overflow_q;
    assign load_pending = load_pending_q;

endmodule

// File: tb/tb_mbr_queue.sv
// tb_mbr_queue: scenario tasks with a scoreboard of expected store-queue data
module tb_mbr_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] control_signals = '0;
    logic [15:0] acc2mbr = '0;
    logic [15:0] mem2mbr = '0;
    logic        mem_rvalid = 1'b0;
    logic        wr_ready = 1'b0;
    logic [15:0] mbr_data, wr_data;
    logic        wr_valid, load_pending, full, empty, overflow;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    int  m_count = 0;
    bit  m_ovf = 0;

    localparam logic [15:0] ST = 16'h0400;
    localparam logic [15:0] LD = 16'h0020;

    mbr_queue dut (
        .clk(clk), .rst(rst), .control_signals(control_signals),
        .acc2mbr(acc2mbr), .mem2mbr(mem2mbr), .mem_rvalid(mem_rvalid),
        .mbr_data(mbr_data), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .load_pending(load_pending), .full(full),
        .empty(empty), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // one clock with scoreboard bookkeeping; pops are compared before the edge
    task automatic step();
        bit p;
        p = wr_ready && (m_count > 0);
        if (p) begin
            checks++;
            if (wr_data !== sb[0]) begin
                errors++;
                $display("FAIL pop_data: got %h expected %h", wr_data, sb[0]);
            end
            void'(sb.pop_front());
        end
        if (control_signals[10]) begin
            if (m_count < 4 || p) begin
                sb.push_back(acc2mbr);
                if (!p) m_count++;
            end else m_ovf = 1;
        end else if (p) m_count--;
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [15:0] d);
        control_signals = ST;
        acc2mbr = d;
        step();
        control_signals = '0;
    endtask

    task automatic drain();
        wr_ready = 1'b1;
        while (m_count > 0) step();
        wr_ready = 1'b0;
        checks++;
        if (empty !== 1'b1 || wr_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: got empty=%b wr_valid=%b expected 1/0", empty, wr_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mbr_data !== 16'h0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
            wr_valid !== 1'b0 || overflow !== 1'b0 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset: got mbr=%h cnt=%0d e=%b f=%b v=%b ov=%b lp=%b expected 0/0/1/0/0/0/0",
                     mbr_data, count, empty, full, wr_valid, overflow, load_pending);
        end
        rst = 1'b0;
        sb.delete();
        m_count = 0;
        m_ovf = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_store();
        store(16'h1234);
        checks++;
        if (mbr_data !== 16'h1234 || wr_valid !== 1'b1 || wr_data !== 16'h1234 || count !== 3'd1) begin
            errors++;
            $display("FAIL store: got mbr=%h v=%b wd=%h cnt=%0d expected 1234/1/1234/1",
                     mbr_data, wr_valid, wr_data, count);
        end
        drain();
    endtask

    task automatic test_overflow_drain();
        for (int i = 0; i < 5; i++) begin
            store(16'hA0 + 16'(i));
            if (i == 3) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL full_at_4: got full=%b ov=%b expected 1/0", full, overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || mbr_data !== 16'h00A4 || count !== 3'd4 || wr_data !== 16'h00A0) begin
            errors++;
            $display("FAIL overflow: got ov=%b mbr=%h cnt=%0d wd=%h expected 1/00a4/4/00a0",
                     overflow, mbr_data, count, wr_data);
        end
        drain();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) store(16'h10 + 16'(i));
        wr_ready = 1'b1;
        store(16'h0055);
        wr_ready = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== m_ovf || mbr_data !== 16'h0055) begin
            errors++;
            $display("FAIL full_push_pop: got cnt=%0d f=%b ov=%b mbr=%h expected 4/1/%b/0055",
                     count, full, overflow, mbr_data, m_ovf);
        end
        drain();
    endtask

    task automatic test_load_wait();
        control_signals = LD;
        step();
        control_signals = '0;
        checks++;
        if (load_pending !== 1'b1) begin
            errors++;
            $display("FAIL load_pending: got %b expected 1", load_pending);
        end
        repeat (3) step();
        checks++;
        if (load_pending !== 1'b1 || mbr_data !== 16'h0055) begin
            errors++;
            $display("FAIL load_hold: got lp=%b mbr=%h expected 1/0055", load_pending, mbr_data);
        end
        mem_rvalid = 1'b1;
        mem2mbr = 16'hBEEF;
        step();
        mem2mbr = 16'h1111;
        control_signals = '0;
        step();
        mem_rvalid = 1'b0;
        checks++;
        if (mbr_data !== 16'hBEEF || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL load_capture: got mbr=%h lp=%b expected beef/0", mbr_data, load_pending);
        end
    endtask

    task automatic test_wait_store();
        control_signals = LD;
        step();
        store(16'h0021);
        checks++;
        if (mbr_data !== 16'h0021 || load_pending !== 1'b1) begin
            errors++;
            $display("FAIL wait_store: got mbr=%h lp=%b expected 0021/1", mbr_data, load_pending);
        end
        mem_rvalid = 1'b1;
        mem2mbr = 16'h0099;
        store(16'h0022);
        mem_rvalid = 1'b0;
        checks++;
        if (mbr_data !== 16'h0022 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL wait_store_capture: got mbr=%h lp=%b expected 0022/0", mbr_data, load_pending);
        end
        drain();
    endtask

    task automatic test_priority();
        mem_rvalid = 1'b1;
        mem2mbr = 16'hF0F0;
        control_signals = ST | LD;
        acc2mbr = 16'h0F0F;
        step();
        control_signals = '0;
        mem_rvalid = 1'b0;
        step();
        checks++;
        if (mbr_data !== 16'h0F0F || count !== 3'd1 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL priority: got mbr=%h cnt=%0d lp=%b expected 0f0f/1/0", mbr_data, count, load_pending);
        end
        drain();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) store(16'hC0 + 16'(i));
        control_signals = LD;
        step();
        control_signals = '0;
        checks++;
        if (load_pending !== 1'b1 || count !== 3'd3) begin
            errors++;
            $display("FAIL pre_reset: got lp=%b cnt=%0d expected 1/3", load_pending, count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (mbr_data !== 16'h0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 ||
            wr_valid !== 1'b0 || overflow !== 1'b0 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got mbr=%h cnt=%0d e=%b f=%b v=%b ov=%b lp=%b expected 0/0/1/0/0/0/0",
                     mbr_data, count, empty, full, wr_valid, overflow, load_pending);
        end
        sb.delete();
        m_count = 0;
        m_ovf = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        store(16'h0777);
        checks++;
        if (count !== 3'd1 || wr_data !== 16'h0777 || load_pending !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got cnt=%0d wd=%h lp=%b expected 1/0777/0", count, wr_data, load_pending);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_store();
        test_overflow_drain();
        test_full_push_pop();
        test_load_wait();
        test_wait_store();
        test_priority();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
